// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state type, limits and helpers for the bus arbiter
package bus_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
   localparam int MAX_REQ = 16;
   localparam int MAX_HOLD_DEF = 8;
   localparam int HOLD_W_DEF = $clog2(MAX_HOLD_DEF);
   function automatic int hold_w(input int max_hold);
      return $clog2(max_hold);
   endfunction
   function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
      return (idx >= 0 && idx < n) ? MAX_REQ'(1) << idx : '0;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search, first set req bit from ptr upward with wrap
//   req     in  : level requests
//   ptr     in  : highest-priority index
//   winner  out : index of the first requester found
//   any_req out : at least one request is set
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  winner,
   output logic             any_req
);
   logic found;
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[(int'(ptr) + i) % N_REQ]) begin
            winner = ID_W'((int'(ptr) + i) % N_REQ);
            found  = 1'b1;
         end
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared data bus with hold limit and high-Z turnaround
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level request per requester
//   gnt        : one-hot drive-enable per tri-state buffer
//   owner_id   : current owner index, 0 when idle
//   bus_busy   : some gnt bit is set
//   timeout    : single-cycle pulse on a forced release
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter  int N_REQ    = 4,
   parameter  int MAX_HOLD = 8,
   localparam int ID_W     = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  owner_id,
   output logic             bus_busy,
   output logic             timeout
);
   localparam int HOLD_W = hold_w(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d, owner_q, owner_d, win;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d, win_oh;
   logic               busy_q, timeout_q, timeout_d, any_req;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .winner  (win),
      .any_req (any_req)
   );

   assign win_oh = N_REQ'(onehot(int'(win), N_REQ));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      timeout_d = 1'b0;
      case (state_q)
         OWN: begin
            if (!req[owner_q] || hold_q == HOLD_LAST) begin
               state_d   = TURN;
               gnt_d     = '0;
               owner_d   = '0;
               ptr_d     = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
               // an owner still requesting at release was forced off by the hold limit
               timeout_d = req[owner_q];
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         // IDLE and TURN arbitrate the same way; TURN has already dropped gnt for one cycle
         default: begin
            state_d = any_req ? OWN : IDLE;
            gnt_d   = any_req ? win_oh : '0;
            owner_d = any_req ? win : '0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         busy_q    <= |gnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt      = gnt_q;
   assign owner_id = owner_q;
   assign bus_busy = busy_q;
   assign timeout  = timeout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench against an ownership-level reference model
module tb_bus_arbiter;
   localparam int N = 4;
   localparam int MH = 8;
   localparam int IW = 2;
   localparam int BOUND = (N - 1) * (MH + 1) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  gnt;
   logic [IW-1:0] owner_id;
   logic          bus_busy, timeout;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [N-1:0]  g;
      logic [IW-1:0] o;
      logic          b;
      logic          t;
   } exp_t;
   exp_t q[$];

   bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .gnt      (gnt),
      .owner_id (owner_id),
      .bus_busy (bus_busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: who owns the bus and for how many cycles so far
   int   m_owner = -1;
   int   m_len = 0;
   int   m_ptr = 0;
   logic m_to = 1'b0;

   function automatic exp_t m_out();
      exp_t e;
      e.g = (m_owner >= 0) ? N'(1) << m_owner : '0;
      e.o = (m_owner >= 0) ? IW'(m_owner) : '0;
      e.b = (m_owner >= 0);
      e.t = m_to;
      return e;
   endfunction

   always @(negedge rst_n) begin
      m_owner = -1; m_len = 0; m_ptr = 0; m_to = 1'b0;
      q.delete();
      q.push_back(m_out());
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1; m_len = 0; m_ptr = 0; m_to = 1'b0;
      end else if (m_owner >= 0) begin
         if (!req[m_owner] || m_len == MH) begin
            m_to = req[m_owner];
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_len++;
            m_to = 1'b0;
         end
      end else begin
         m_to = 1'b0;
         for (int i = 0; i < N; i++)
            if (m_owner < 0 && req[(m_ptr + i) % N]) begin
               m_owner = (m_ptr + i) % N;
               m_len = 1;
            end
      end
      q.push_back(m_out());
   end

   // monitor: compare every presented output cycle and track requester wait times
   int wt[N];
   int max_wt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("gnt", gnt, e.g);
         check("owner_id", owner_id, e.o);
         check("bus_busy", bus_busy, e.b);
         check("timeout", timeout, e.t);
         check("onehot0", $onehot0(gnt), 1);
      end
      for (int i = 0; i < N; i++) begin
         wt[i] = (rst_n && req[i] && !gnt[i]) ? wt[i] + 1 : 0;
         if (wt[i] > max_wt) max_wt = wt[i];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit got;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      // reset mid-ownership
      req = 4'b0001;
      got = 1'b0;
      for (int i = 0; i < 5 && !got; i++) begin
         cyc();
         got = (gnt == 4'b0001);
      end
      check("grant_seen", got, 1);
      #1 rst_n = 1'b0;
      #1 check("async_clear", gnt, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("regrant", gnt, 4'b0001);
      req = '0;
      repeat (3) cyc();
      // single voluntary release
      req = 4'b0010;
      repeat (3) cyc();
      req = '0;
      repeat (4) cyc();
      // round-robin fairness
      req = 4'b1111;
      repeat (40) cyc();
      req = '0;
      repeat (3) cyc();
      // lone hog
      req = 4'b0100;
      repeat (20) cyc();
      req = '0;
      repeat (3) cyc();
      // drop on the last allowed cycle while another requester waits
      req = 4'b0001;
      cyc();
      req = 4'b1001;
      repeat (7) cyc();
      req = 4'b1000;
      cyc();
      check("late_drop_timeout", timeout, 0);
      check("late_drop_gap", gnt, 0);
      cyc();
      check("late_drop_next", gnt, 4'b1000);
      req = '0;
      repeat (3) cyc();
      // random contention
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         cyc();
      end
      req = '0;
      repeat (3) cyc();
      check("max_wait_ok", max_wt <= BOUND, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
